seven_seg_scanner: RTL and testbench
====================================

// Module: seven_seg_scanner
// PURPOSE
//   Time-multiplexes NUM_DIGITS hex nibbles onto one shared SevenSegment decoder and a common 7-bit segment bus.
//   Drives the decoder's 4-bit hex input, captures its 7-bit GFEDCBA pattern and enables one digit at a time.
//   Inserts a blanking gap between digits to suppress ghosting.
//   Double-buffers the display value so a new value only appears at a frame boundary (no tearing).
// PARAMETERS
//   NUM_DIGITS    4      digits scanned; 2..8
//   REFRESH_DIV   50000  clk cycles each digit is lit (SHOW); >=1
//   BLANK_CYCLES  2      clk cycles all digits dark before each digit (BLANK); >=2
// PORTS
//   clk        in   1             system clock, rising edge
//   reset      in   1             asynchronous, active-high
//   enable     in   1             1 = scan; 0 = display dark, return to IDLE
//   value      in   4*NUM_DIGITS  nibble i = value[4i+3:4i]; digit 0 = rightmost
//   load       in   1             1-cycle strobe: capture value into staging register
//   seg_in     in   7             GFEDCBA pattern from shared SevenSegment decoder
//   hex_out    out  4             nibble to SevenSegment decoder hex input
//   seg_out    out  7             registered segment drive, 1 = segment on
//   digit_en   out  NUM_DIGITS    one-hot active-high digit enable; all 0 while blanked
//   frame_done out  1             1-cycle pulse when the last digit's SHOW ends
// BEHAVIOUR
//   Reset (async): state=IDLE, idx=0, cnt=0, staged=0, shadow=0, pending=0.
//     Outputs: hex_out=0, seg_out=0, digit_en=0, frame_done=0.
//   Registers:
//     cnt: width $clog2(max(REFRESH_DIV,BLANK_CYCLES)+1).
//     idx: width $clog2(NUM_DIGITS).
//     staged, shadow: 4*NUM_DIGITS each.
//   load: staged<=value, pending<=1, in any state. Repeated loads overwrite staged; last one wins.
//   hex_out = shadow nibble[idx], registered, updated on entry to BLANK.
//   seg_out <= seg_in every cycle in BLANK/SHOW; forced 0 in IDLE. This is a 1-cycle decoder latency.
//     Valid by the 2nd BLANK cycle, hence BLANK_CYCLES>=2.
//   FSM:
//     IDLE : digit_en=0. When enable=1 -> BLANK, cnt=0, idx=0.
//            If pending=1 on this transition: shadow<=staged, pending<=0.
//     BLANK: digit_en=0, for BLANK_CYCLES cycles (cnt 0..BLANK_CYCLES-1). Then -> SHOW, cnt=0.
//     SHOW : digit_en=1<<idx, for REFRESH_DIV cycles. Then:
//            if idx==NUM_DIGITS-1: idx<=0, frame_done=1 that cycle; if pending, shadow<=staged, pending<=0.
//            else idx<=idx+1.
//            Next state: BLANK.
//   Frame period = NUM_DIGITS*(BLANK_CYCLES+REFRESH_DIV) cycles.
//   enable=0 in BLANK/SHOW: next cycle state=IDLE; digit_en=0, seg_out=0, idx=0, cnt=0.
//     staged, shadow and pending are kept.
//   load in the same cycle as a frame-boundary swap:
//     the swap uses the pre-load staged value;
//     the new value stays staged with pending=1 and appears next frame.
//   digit_en is never multi-hot. No digit is enabled during the cycle hex_out changes.
// CONFIGURATION
//   SEVENSEG_LZB_EN defined: leading-zero blanking. In SHOW, digit_en is held 0 for digit idx when:
//     idx>0, and shadow nibbles idx..NUM_DIGITS-1 are all 0.
//     Digit 0 is always shown. Timing and frame_done are unchanged.
//   SEVENSEG_LZB_EN undefined: every digit is shown, including leading zeros.
// TESTING  (NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=2; frame = 24 cycles)
//   1. Reset mid-SHOW at random cycle -> same-cycle async: digit_en=0, seg_out=0, hex_out=0.
//        After release with enable=0: stays IDLE.
//   2. load value=16'h1234, enable=1.
//        hex_out sequence 4,3,2,1. digit_en 0001,0010,0100,1000, each high 4 cycles, 2 dark cycles between.
//        seg_out during SHOW = 0x66,0x4F,0x5B,0x06. frame_done pulses every 24 cycles.
//   3. While scanning 16'h1234, load 16'hABCD at digit 1:
//        remainder of frame still shows 1234; next frame shows D,C,B,A (seg 0x5E,0x39,0x7C,0x77).
//   4. load 16'h0000, then 16'hFFFF two cycles later, same frame -> next frame shows FFFF only (0x71 x4).
//   5. enable dropped during digit 2 SHOW -> next cycle digit_en=0, seg_out=0.
//        Re-enable -> restarts at digit 0 after 2 blank cycles.
//   6. SEVENSEG_LZB_EN defined, value=16'h0050:
//        digits 0,1 enabled; digits 2,3 digit_en stay 0; frame still 24 cycles.
//        value=16'h0000 -> only digit 0 lit (0x3F).

Source files
------------

// File: rtl/seven_seg_scanner.sv
// Scans NUM_DIGITS hex nibbles through one shared seven-segment decoder, with blanking gaps and a
// frame-synchronous double buffer. Define SEVENSEG_LZB_EN to enable leading-zero blanking.
module seven_seg_scanner #(
   parameter int NUM_DIGITS   = 4,
   parameter int REFRESH_DIV  = 50000,
   parameter int BLANK_CYCLES = 2
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      enable,
   input  logic [4*NUM_DIGITS-1:0]   value,
   input  logic                      load,
   input  logic [6:0]                seg_in,
   output logic [3:0]                hex_out,
   output logic [6:0]                seg_out,
   output logic [NUM_DIGITS-1:0]     digit_en,
   output logic                      frame_done
);

   localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam int IW      = $clog2(NUM_DIGITS);
   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
   localparam logic [CW-1:0] SHOW_LAST  = CW'(REFRESH_DIV - 1);
   localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
   localparam logic [NUM_DIGITS-1:0] ONE_HOT0 = {{(NUM_DIGITS-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BLANK = 2'd1,
      SHOW  = 2'd2
   } state_t;

   state_t                    state, state_n;
   logic [CW-1:0]             cnt, cnt_n;
   logic [IW-1:0]             idx, idx_n;
   logic [4*NUM_DIGITS-1:0]   staged, shadow, shadow_n;
   logic                      pending;
   logic                      swap;
   logic [NUM_DIGITS-1:0]     digit_en_n;
   logic                      frame_done_n;

`ifdef SEVENSEG_LZB_EN
   // True when digit i is a leading zero: i>0 and every nibble from i upward is zero.
   function automatic logic lead_blank(input logic [4*NUM_DIGITS-1:0] val, input logic [IW-1:0] i);
      logic z;
      z = (i != {IW{1'b0}});
      for (int j = 0; j < NUM_DIGITS; j++) begin
         if ((IW'(j) >= i) && (val[4*j +: 4] != 4'h0)) begin
            z = 1'b0;
         end else begin
            z = z;
         end
      end
      return z;
   endfunction
`endif

   // Next-state, counter and index sequencing; swap marks a frame-boundary buffer transfer.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      idx_n   = idx;
      swap    = 1'b0;
      case (state)
         IDLE: begin
            if (enable) begin
               state_n = BLANK;
               cnt_n   = {CW{1'b0}};
               idx_n   = {IW{1'b0}};
               swap    = pending;
            end else begin
               state_n = IDLE;
            end
         end
         BLANK: begin
            if (!enable) begin
               state_n = IDLE;
               cnt_n   = {CW{1'b0}};
               idx_n   = {IW{1'b0}};
            end else if (cnt == BLANK_LAST) begin
               state_n = SHOW;
               cnt_n   = {CW{1'b0}};
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         SHOW: begin
            if (!enable) begin
               state_n = IDLE;
               cnt_n   = {CW{1'b0}};
               idx_n   = {IW{1'b0}};
            end else if (cnt == SHOW_LAST) begin
               state_n = BLANK;
               cnt_n   = {CW{1'b0}};
               if (idx == IDX_LAST) begin
                  idx_n = {IW{1'b0}};
                  swap  = pending;
               end else begin
                  idx_n = idx + IW'(1);
               end
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         default: begin
            state_n = IDLE;
            cnt_n   = {CW{1'b0}};
            idx_n   = {IW{1'b0}};
         end
      endcase
   end

   // Look-ahead output decode so digit_en and frame_done can be registered in step with state.
   always_comb begin
      shadow_n     = swap ? staged : shadow;
      digit_en_n   = {NUM_DIGITS{1'b0}};
      frame_done_n = (state_n == SHOW) && (idx_n == IDX_LAST) && (cnt_n == SHOW_LAST);
      if (state_n == SHOW) begin
         digit_en_n = ONE_HOT0 << idx_n;
`ifdef SEVENSEG_LZB_EN
         if (lead_blank(shadow_n, idx_n)) begin
            digit_en_n = {NUM_DIGITS{1'b0}};
         end else begin
            digit_en_n = ONE_HOT0 << idx_n;
         end
`endif
      end else begin
         digit_en_n = {NUM_DIGITS{1'b0}};
      end
   end

   // Scan sequencer registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= {CW{1'b0}};
         idx   <= {IW{1'b0}};
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         idx   <= idx_n;
      end
   end

   // Double buffer: a load landing on a swap edge stays pending for the following frame.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         staged  <= {(4*NUM_DIGITS){1'b0}};
         shadow  <= {(4*NUM_DIGITS){1'b0}};
         pending <= 1'b0;
      end else begin
         shadow <= shadow_n;
         if (load) begin
            staged  <= value;
            pending <= 1'b1;
         end else if (swap) begin
            pending <= 1'b0;
         end else begin
            pending <= pending;
         end
      end
   end

   // Registered display outputs; hex_out only moves on entry to BLANK, while every digit is dark.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hex_out    <= 4'h0;
         seg_out    <= 7'h00;
         digit_en   <= {NUM_DIGITS{1'b0}};
         frame_done <= 1'b0;
      end else begin
         if ((state_n == BLANK) && (state != BLANK)) begin
            hex_out <= shadow_n[{idx_n, 2'b00} +: 4];
         end else begin
            hex_out <= hex_out;
         end
         if ((state != IDLE) && (state_n != IDLE)) begin
            seg_out <= seg_in;
         end else begin
            seg_out <= 7'h00;
         end
         digit_en   <= digit_en_n;
         frame_done <= frame_done_n;
      end
   end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed, table-driven bench for seven_seg_scanner (4 digits, REFRESH_DIV=4, BLANK_CYCLES=2).
// Models the external hex-to-GFEDCBA decoder on seg_in.
module tb_seven_seg_scanner;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic [15:0] value;
   logic        load;
   logic [6:0]  seg_in;
   logic [3:0]  hex_out;
   logic [6:0]  seg_out;
   logic [3:0]  digit_en;
   logic        frame_done;

   int checks = 0;
   int errors = 0;

   seven_seg_scanner #(.NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_CYCLES(2)) dut (
      .clk(clk), .reset(reset), .enable(enable), .value(value), .load(load),
      .seg_in(seg_in), .hex_out(hex_out), .seg_out(seg_out),
      .digit_en(digit_en), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] seg_lut(input logic [3:0] h);
      case (h)
         4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
         4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
         4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
         4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
      endcase
   endfunction

   assign seg_in = seg_lut(hex_out);

   typedef struct {
      logic [15:0] show;   // value displayed during this frame
      logic [3:0]  mask;   // digits expected to light
      logic [27:0] seg;    // {d3,d2,d1,d0} expected segment patterns
      int          pos_a;  // frame position of first load (-1 none)
      logic [15:0] val_a;
      int          pos_b;  // frame position of second load (-1 none)
      logic [15:0] val_b;
   } vec_t;

   vec_t vec [5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Frame position p: 0..1 blank, 2..5 show for digit p/6; frame_done only at p=23.
   task automatic check_cycle(input vec_t v, input int p);
      int d, ph;
      logic [15:0] sv;
      logic [27:0] sg;
      logic [3:0]  oh;
      d  = p / 6;
      ph = p % 6;
      sv = v.show;
      sg = v.seg;
      oh = 4'b0001 << d;
      chk($sformatf("hex_out p%0d", p), {28'h0, hex_out}, {28'h0, sv[4*d +: 4]});
      if (ph >= 2) begin
         chk($sformatf("digit_en p%0d", p), {28'h0, digit_en}, {28'h0, (v.mask[d] ? oh : 4'b0000)});
         chk($sformatf("seg_out p%0d", p), {25'h0, seg_out}, {25'h0, sg[7*d +: 7]});
      end else begin
         chk($sformatf("digit_en blank p%0d", p), {28'h0, digit_en}, 32'h0);
      end
      chk($sformatf("frame_done p%0d", p), {31'h0, frame_done}, {31'h0, (p == 23)});
   endtask

   initial begin
      vec[0] = '{16'h1234, 4'hF, {7'h06, 7'h5B, 7'h4F, 7'h66}, 7, 16'hABCD, -1, 16'h0000};
      vec[1] = '{16'hABCD, 4'hF, {7'h77, 7'h7C, 7'h39, 7'h5E}, 3, 16'h0000, 5, 16'hFFFF};
      vec[2] = '{16'hFFFF, 4'hF, {7'h71, 7'h71, 7'h71, 7'h71}, 7, 16'h5678, 23, 16'h0050};
      vec[3] = '{16'h5678, 4'hF, {7'h6D, 7'h7D, 7'h07, 7'h7F}, -1, 16'h0000, -1, 16'h0000};
`ifdef SEVENSEG_LZB_EN
      vec[4] = '{16'h0050, 4'b0011, {7'h3F, 7'h3F, 7'h6D, 7'h3F}, -1, 16'h0000, -1, 16'h0000};
`else
      vec[4] = '{16'h0050, 4'hF, {7'h3F, 7'h3F, 7'h6D, 7'h3F}, -1, 16'h0000, -1, 16'h0000};
`endif

      reset  = 1'b1;
      enable = 1'b0;
      load   = 1'b0;
      value  = 16'h0000;
      #1;
      chk("reset hex_out", {28'h0, hex_out}, 32'h0);
      chk("reset seg_out", {25'h0, seg_out}, 32'h0);
      chk("reset digit_en", {28'h0, digit_en}, 32'h0);
      chk("reset frame_done", {31'h0, frame_done}, 32'h0);
      repeat (2) @(posedge clk);
      #3 reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("idle digit_en", {28'h0, digit_en}, 32'h0);
         chk("idle seg_out", {25'h0, seg_out}, 32'h0);
      end

      // Stage 1234, then start scanning; frame position 0 is the first BLANK cycle.
      value = 16'h1234;
      load  = 1'b1;
      step();
      load   = 1'b0;
      enable = 1'b1;
      step();

      for (int f = 0; f < 5; f++) begin
         for (int p = 0; p < 24; p++) begin
            check_cycle(vec[f], p);
            load  = (p == vec[f].pos_a) || (p == vec[f].pos_b);
            value = (p == vec[f].pos_b) ? vec[f].val_b : vec[f].val_a;
            step();
         end
      end
      load = 1'b0;

      // Drop enable in digit 2 SHOW, then restart from digit 0.
      for (int p = 0; p < 16; p++) begin
         check_cycle(vec[4], p);
         step();
      end
      enable = 1'b0;
      step();
      chk("disable digit_en", {28'h0, digit_en}, 32'h0);
      chk("disable seg_out", {25'h0, seg_out}, 32'h0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("disabled digit_en", {28'h0, digit_en}, 32'h0);
         chk("disabled frame_done", {31'h0, frame_done}, 32'h0);
      end
      enable = 1'b1;
      step();
      for (int p = 0; p < 4; p++) begin
         check_cycle(vec[4], p);
         if (p < 3) begin
            step();
         end else begin
            #2;
         end
      end

      // Asynchronous reset during SHOW of digit 0.
      reset = 1'b1;
      #1;
      chk("async hex_out", {28'h0, hex_out}, 32'h0);
      chk("async seg_out", {25'h0, seg_out}, 32'h0);
      chk("async digit_en", {28'h0, digit_en}, 32'h0);
      chk("async frame_done", {31'h0, frame_done}, 32'h0);
      enable = 1'b0;
      #2 reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("post-reset digit_en", {28'h0, digit_en}, 32'h0);
         chk("post-reset seg_out", {25'h0, seg_out}, 32'h0);
         chk("post-reset hex_out", {28'h0, hex_out}, 32'h0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
